fetch_queue_stage: RTL and testbench

FETCH_QUEUE_STAGE -- requirements
Module: fetch_queue_stage

---
 rtl/fetch_queue_stage_pkg.sv | 10 +
 rtl/fetch_iqueue.sv | 67 ++++++
 rtl/fetch_queue_stage.sv | 115 +++++++++++
 tb/tb_fetch_queue_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_stage_pkg.sv
// fetch_queue_stage_pkg: shared data width default, instruction size and redirect-source encoding.
package fetch_queue_stage_pkg;
    localparam int unsigned D_WIDTH_DEF = 32;
    localparam int unsigned INSTR_BYTES = 4;
    typedef enum logic [1:0] {
        REDIR_NONE,
        REDIR_EXEC,
        REDIR_WB
    } redir_src_e;
endpackage

// File: rtl/fetch_iqueue.sv
// fetch_iqueue: circular instruction buffer, enqueues FETCH_W entries at once and dequeues up to FETCH_W.
module fetch_iqueue #(
    parameter int D_WIDTH = 32,
    parameter int FETCH_W = 2,
    parameter int QDEPTH = 8,
    localparam int CW = $clog2(FETCH_W + 1),
    localparam int OW = $clog2(QDEPTH + 1),
    localparam int PW = $clog2(QDEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic                       i_enq,
    input  logic [FETCH_W*D_WIDTH-1:0] i_enq_instr,
    input  logic [FETCH_W*D_WIDTH-1:0] i_enq_pc,
    input  logic [CW-1:0]              i_deq_cnt,
    output logic [FETCH_W-1:0]         o_valid,
    output logic [FETCH_W*D_WIDTH-1:0] o_instr,
    output logic [FETCH_W*D_WIDTH-1:0] o_pc,
    output logic [OW-1:0]              o_count
);
    logic [D_WIDTH-1:0] r_instr [QDEPTH];
    logic [D_WIDTH-1:0] r_pc    [QDEPTH];
    logic [PW-1:0]      r_rd;
    logic [PW-1:0]      r_wr;
    logic [OW-1:0]      r_count;
    logic [CW-1:0]      w_avail;
    logic [CW-1:0]      w_deq;
    logic               w_enq;

    // Over-asking consumers are clamped to what the head actually holds.
    assign w_avail = r_count >= OW'(FETCH_W) ? CW'(FETCH_W) : CW'(r_count);
    assign w_deq   = i_deq_cnt > w_avail ? w_avail : i_deq_cnt;
    assign w_enq   = i_enq && !i_flush;
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            r_rd    <= r_rd + PW'(w_deq);
            r_wr    <= w_enq ? r_wr + PW'(FETCH_W) : r_wr;
            r_count <= r_count - OW'(w_deq) + (w_enq ? OW'(FETCH_W) : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            for (int k = 0; k < FETCH_W; k++) begin
                r_instr[r_wr + PW'(k)] <= i_enq_instr[k*D_WIDTH +: D_WIDTH];
                r_pc[r_wr + PW'(k)]    <= i_enq_pc[k*D_WIDTH +: D_WIDTH];
            end
        end
    end

    for (genvar g = 0; g < FETCH_W; g++) begin : g_head
        assign o_valid[g]                   = r_count > OW'(g);
        assign o_instr[g*D_WIDTH +: D_WIDTH] = r_instr[r_rd + PW'(g)];
        assign o_pc[g*D_WIDTH +: D_WIDTH]    = r_pc[r_rd + PW'(g)];
    end
endmodule

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: PC sequencing, redirect handling and instruction-queue front end.
// Defining FETCH_PERF_CNT_EN adds saturating o_StallCnt / o_RedirCnt counters.
module fetch_queue_stage
    import fetch_queue_stage_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int FETCH_W = 2,
    parameter int QDEPTH = 8,
    parameter logic [D_WIDTH-1:0] RESET_PC = '0,
    localparam int CW = $clog2(FETCH_W + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_StallF,
    input  logic [FETCH_W-1:0]         i_Branch_TakenE,
    input  logic [FETCH_W*D_WIDTH-1:0] i_ALUResultE,
    input  logic [FETCH_W-1:0]         i_PCSrcW,
    input  logic [FETCH_W*D_WIDTH-1:0] i_ResultW,
    output logic                       o_IMemReq,
    output logic [D_WIDTH-1:0]         o_IMemAddr,
    input  logic [FETCH_W*D_WIDTH-1:0] i_IMemData,
    output logic [FETCH_W-1:0]         o_Valid,
    output logic [FETCH_W*D_WIDTH-1:0] o_Instr,
    output logic [FETCH_W*D_WIDTH-1:0] o_PC,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]                o_StallCnt,
    output logic [31:0]                o_RedirCnt,
`endif
    input  logic [CW-1:0]              i_DeqCnt
);
    localparam int OW = $clog2(QDEPTH + 1);
    localparam logic [D_WIDTH-1:0] STEP = D_WIDTH'(INSTR_BYTES * FETCH_W);

    function automatic logic [D_WIDTH-1:0] f_pick(input logic [FETCH_W-1:0] sel,
                                                  input logic [FETCH_W*D_WIDTH-1:0] data);
        f_pick = '0;
        for (int k = FETCH_W - 1; k >= 0; k--)
            if (sel[k]) f_pick = data[k*D_WIDTH +: D_WIDTH];
    endfunction

    redir_src_e               w_src;
    logic [D_WIDTH-1:0]       r_pc;
    logic [D_WIDTH-1:0]       r_resp_pc;
    logic [D_WIDTH-1:0]       w_target;
    logic                     r_inflight;
    logic                     w_flush;
    logic                     w_space;
    logic                     w_req;
    logic                     w_enq;
    logic [OW-1:0]            w_count;
    logic [OW-1:0]            w_free;
    logic [FETCH_W*D_WIDTH-1:0] w_enq_pc;

    assign w_src    = |i_Branch_TakenE ? REDIR_EXEC : |i_PCSrcW ? REDIR_WB : REDIR_NONE;
    assign w_target = w_src == REDIR_EXEC ? f_pick(i_Branch_TakenE, i_ALUResultE)
                                          : f_pick(i_PCSrcW, i_ResultW);
    assign w_flush  = w_src != REDIR_NONE;
    // Room must exist for the group already in flight as well as the new one.
    assign w_free   = OW'(QDEPTH) - w_count;
    assign w_space  = w_free >= (r_inflight ? OW'(2 * FETCH_W) : OW'(FETCH_W));
    assign w_req    = rst_n && !i_StallF && !w_flush && w_space;
    assign w_enq    = r_inflight && !w_flush;
    assign o_IMemReq  = w_req;
    assign o_IMemAddr = r_pc;

    for (genvar g = 0; g < FETCH_W; g++) begin : g_pc
        assign w_enq_pc[g*D_WIDTH +: D_WIDTH] = r_resp_pc + D_WIDTH'(INSTR_BYTES * g);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_inflight <= 1'b0;
        end else begin
            r_pc       <= w_flush ? w_target : w_req ? r_pc + STEP : r_pc;
            r_resp_pc  <= w_req ? r_pc : r_resp_pc;
            r_inflight <= w_req;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_redir_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_redir_cnt <= '0;
        end else begin
            if (!i_StallF && !w_flush && !w_space && ~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_flush && ~&r_redir_cnt) r_redir_cnt <= r_redir_cnt + 32'd1;
        end
    end
    assign o_StallCnt = r_stall_cnt;
    assign o_RedirCnt = r_redir_cnt;
`endif

    fetch_iqueue #(
        .D_WIDTH(D_WIDTH),
        .FETCH_W(FETCH_W),
        .QDEPTH (QDEPTH)
    ) u_iqueue (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (w_flush),
        .i_enq      (w_enq),
        .i_enq_instr(i_IMemData),
        .i_enq_pc   (w_enq_pc),
        .i_deq_cnt  (i_DeqCnt),
        .o_valid    (o_Valid),
        .o_instr    (o_Instr),
        .o_pc       (o_PC),
        .o_count    (w_count)
    );
endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage: scoreboard bench with a program-order fetch-stream reference model.
module tb_fetch_queue_stage;
    localparam int DW = 32;
    localparam int FW = 2;
    localparam int QD = 8;
    localparam logic [31:0] RPC = 32'h100;

    logic clk = 0;
    logic rst_n = 0;
    logic i_StallF = 1;
    logic [FW-1:0] i_Branch_TakenE = '0;
    logic [FW-1:0] i_PCSrcW = '0;
    logic [FW*DW-1:0] i_ALUResultE = '0;
    logic [FW*DW-1:0] i_ResultW = '0;
    logic [FW*DW-1:0] i_IMemData = '0;
    logic [1:0] i_DeqCnt = '0;
    logic o_IMemReq;
    logic [DW-1:0] o_IMemAddr;
    logic [FW-1:0] o_Valid;
    logic [FW*DW-1:0] o_Instr;
    logic [FW*DW-1:0] o_PC;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] o_StallCnt;
    logic [31:0] o_RedirCnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_pc = RPC;
    logic [31:0] m_resp_pc = RPC;
    bit m_inflight = 0;
    bit m_req = 0;
    logic mreq = 0;
    logic [31:0] maddr = '0;

    fetch_queue_stage #(.D_WIDTH(DW), .FETCH_W(FW), .QDEPTH(QD), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .i_StallF(i_StallF),
        .i_Branch_TakenE(i_Branch_TakenE), .i_ALUResultE(i_ALUResultE),
        .i_PCSrcW(i_PCSrcW), .i_ResultW(i_ResultW),
        .o_IMemReq(o_IMemReq), .o_IMemAddr(o_IMemAddr), .i_IMemData(i_IMemData),
        .o_Valid(o_Valid), .o_Instr(o_Instr), .o_PC(o_PC),
`ifdef FETCH_PERF_CNT_EN
        .o_StallCnt(o_StallCnt), .o_RedirCnt(o_RedirCnt),
`endif
        .i_DeqCnt(i_DeqCnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] pc);
        return (pc * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] target(input logic [FW-1:0] bte, input logic [FW*DW-1:0] alu,
                                           input logic [FW-1:0] pcs, input logic [FW*DW-1:0] res);
        for (int k = 0; k < FW; k++) if (bte[k]) return alu[k*DW +: DW];
        for (int k = 0; k < FW; k++) if (pcs[k]) return res[k*DW +: DW];
        return m_pc;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instruction memory: answers the sampled request one cycle later.
    initial forever begin
        @(negedge clk); #2;
        mreq = o_IMemReq;
        maddr = o_IMemAddr;
    end
    initial forever begin
        @(posedge clk); #1;
        for (int k = 0; k < FW; k++)
            i_IMemData[k*DW +: DW] = mreq ? word(maddr + 32'(4 * k)) : $urandom;
    end

    // Monitor: checks request legality and pops dequeued entries against the scoreboard.
    initial forever begin
        @(negedge clk); #2;
        if (mon_en) begin : mon
            int occ;
            int n;
            bit redir;
            logic [FW-1:0] ev;
            logic [31:0] pc;
            occ = exp_q.size();
            redir = |i_Branch_TakenE || |i_PCSrcW;
            m_req = !i_StallF && !redir && (QD - occ >= FW * (1 + int'(m_inflight)));
            for (int k = 0; k < FW; k++) ev[k] = occ > k;
            chk("valid", o_Valid, ev);
            chk("req", o_IMemReq, m_req);
            if (m_req) chk("addr", o_IMemAddr, m_pc);
            if (!redir) begin
                n = int'(i_DeqCnt);
                if (n > occ) n = occ;
                if (n > FW) n = FW;
                for (int k = 0; k < n; k++) begin
                    pc = exp_q.pop_front();
                    chk("head_pc", o_PC[k*DW +: DW], pc);
                    chk("head_instr", o_Instr[k*DW +: DW], word(pc));
                end
            end
        end
    end

    task automatic drive(input bit st, input logic [FW-1:0] bte, input logic [FW*DW-1:0] alu,
                         input logic [FW-1:0] pcs, input logic [FW*DW-1:0] res, input logic [1:0] deq);
        @(negedge clk);
        i_StallF = st;
        i_Branch_TakenE = bte;
        i_ALUResultE = alu;
        i_PCSrcW = pcs;
        i_ResultW = res;
        i_DeqCnt = deq;
        #3;
        if (|bte || |pcs) begin
            exp_q.delete();
            m_pc = target(bte, alu, pcs, res);
            m_inflight = 0;
        end else begin
            if (m_inflight) for (int k = 0; k < FW; k++) exp_q.push_back(m_resp_pc + 32'(4 * k));
            if (m_req) begin
                m_resp_pc = m_pc;
                m_pc = m_pc + 32'(4 * FW);
            end
            m_inflight = m_req;
        end
    endtask

    task automatic go(input bit st, input logic [1:0] deq);
        drive(st, '0, '0, '0, '0, deq);
    endtask

    task automatic do_reset();
        @(negedge clk); #4;
        rst_n = 0;
        mon_en = 0;
        i_StallF = 1;
        i_Branch_TakenE = '0;
        i_PCSrcW = '0;
        i_DeqCnt = '0;
        exp_q.delete();
        m_pc = RPC;
        m_inflight = 0;
        @(negedge clk); #2;
        chk("rst_valid", o_Valid, '0);
        chk("rst_req", o_IMemReq, 0);
        chk("rst_pc", o_IMemAddr, RPC);
        #2;
        rst_n = 1;
        mon_en = 1;
    endtask

    initial begin
        logic [1:0] b;
        logic [1:0] p;
        do_reset();
        go(0, 2);
        chk("first_req", o_IMemReq, 1);
        chk("first_addr", o_IMemAddr, RPC);
        go(0, 2);
        chk("second_addr", o_IMemAddr, RPC + 32'h8);
        go(0, 2);
        chk("valid_3rd", o_Valid, 2'b11);
        chk("pc0_3rd", o_PC[31:0], RPC);
        repeat (5) go(0, 2);
        repeat (10) go(0, 0);
        chk("full_valid", o_Valid, 2'b11);
        chk("full_noreq", o_IMemReq, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt", o_StallCnt >= 32'd6, 1);
`endif
        repeat (6) go(0, 2);
        go(0, 2);
        drive(0, 2'b10, {32'h400, 32'hDEAD0000}, 2'b01, {32'hBEEF0000, 32'h800}, 2);
        go(0, 2);
        chk("redir_empty", o_Valid, '0);
        chk("redir_addr", o_IMemAddr, 32'h400);
        go(0, 2);
        drive(0, 2'b11, {32'h300, 32'h200}, '0, '0, 2);
        go(0, 2);
        chk("lane_prio", o_IMemAddr, 32'h200);
        go(0, 0);
        repeat (5) begin
            go(1, 0);
            chk("stall_noreq", o_IMemReq, 0);
            chk("stall_pc", o_IMemAddr, m_pc);
        end
        chk("stall_enq", o_Valid, 2'b11);
        go(0, 2);
        drive(0, 2'b01, {32'h0, 32'hFFFFFFF8}, '0, '0, 2);
        go(0, 2);
        chk("wrap_pre", o_IMemAddr, 32'hFFFFFFF8);
        go(0, 2);
        chk("wrap_addr", o_IMemAddr, 32'h0);
        go(0, 2);
        do_reset();
        go(0, 2);
        chk("post_rst_addr", o_IMemAddr, RPC);
        go(0, 2);
        chk("post_rst_drop", o_Valid, '0);
        repeat (3000) begin
            b = '0;
            p = '0;
            if ($urandom_range(0, 11) == 0) begin
                b = 2'($urandom);
                p = 2'($urandom);
            end
            drive($urandom_range(0, 4) == 0, b, {$urandom & 32'hFFFFFFFC, $urandom & 32'hFFFFFFFC},
                  p, {$urandom & 32'hFFFFFFFC, $urandom & 32'hFFFFFFFC}, 2'($urandom_range(0, 3)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
